// File: rtl/vel_ramp_sched_pkg.sv
// Shared types and constants for the velocity ramp scheduler.
// Axis count, index width, default widths and the pass FSM encoding.
package vel_ramp_sched_pkg;

    localparam int F_DEF  = 11;
    localparam int AW_DEF = 8;
    localparam int N_AX   = 4;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic int vel_w(input int f);
        return f + 1;
    endfunction

endpackage

// File: rtl/vel_ramp_sched_alu.sv
// Shared clamp-adder: steps vel toward tgt by at most acc, never overshooting.
// Purely combinational; one instance is time-multiplexed over all axes.
module vel_ramp_alu
    import vel_ramp_sched_pkg::*;
#(
    parameter int F  = F_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [F:0]    vel_i,
    input  logic [F:0]    tgt_i,
    input  logic [AW-1:0] acc_i,
    output logic [F:0]    nxt_o,
    output logic          eq_o
);

    // One extra bit over the velocity so full-scale differences fit
    localparam int DW = (F + 2 > AW + 1) ? F + 2 : AW + 1;

    logic signed [DW-1:0] v_s;
    logic signed [DW-1:0] t_s;
    logic signed [DW-1:0] a_s;
    logic signed [DW-1:0] d_s;
    logic signed [DW-1:0] mag;
    logic signed [DW-1:0] sum;

    always_comb begin
        v_s = DW'($signed(vel_i));
        t_s = DW'($signed(tgt_i));
        a_s = DW'(acc_i);
        d_s = t_s - v_s;
        mag = (d_s < 0) ? -d_s : d_s;
        sum = (d_s > 0) ? (v_s + a_s) : (v_s - a_s);
        if (mag <= a_s) begin
            nxt_o = tgt_i;
        end else begin
            nxt_o = sum[F:0];
        end
        eq_o = (nxt_o == tgt_i);
    end

endmodule

// File: rtl/vel_ramp_sched.sv
// Acceleration-limited ramp of four stepgen velocities toward SPI targets.
// Optional RAMP_ESTOP_EN: estop forces all effective targets to zero.
module vel_ramp_sched
    import vel_ramp_sched_pkg::*;
#(
    parameter int F  = F_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  tgt_wr,
    input  logic [IDX_W-1:0]      tgt_idx,
    input  logic [F:0]            tgt_val,
    input  logic [AW-1:0]         acc,
    input  logic                  estop,
    output logic [N_AX*(F+1)-1:0] vel_out,
    output logic [N_AX-1:0]       at_target,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int VW = vel_w(F);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ax_q, ax_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic              ovr_q, ovr_d;
    logic [VW-1:0]     tgt_q [N_AX];
    logic [VW-1:0]     vel_q [N_AX];
    logic [N_AX-1:0]   at_q;
    logic [VW-1:0]     nxt_q;
    logic              eq_q;
    logic              stale_q, stale_d;

    logic              est;
    logic [VW-1:0]     eff_tgt;
    logic [VW-1:0]     alu_nxt;
    logic              alu_eq;
    logic [VW-1:0]     vel_nx;
    logic [AW-1:0]     acc_pick;

`ifdef RAMP_ESTOP_EN
    assign est = estop;
`else
    logic unused_estop;
    assign unused_estop = estop;
    assign est = 1'b0;
`endif

    assign eff_tgt = est ? '0 : tgt_q[ax_q];

    // Zero acc under estop would never stop; substitute the max step
    assign acc_pick = (est && acc == '0) ? '1 : acc;

    vel_ramp_alu #(
        .F  (F),
        .AW (AW)
    ) u_alu (
        .vel_i (vel_q[ax_q]),
        .tgt_i (eff_tgt),
        .acc_i (acc_q),
        .nxt_o (alu_nxt),
        .eq_o  (alu_eq)
    );

    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        acc_d   = acc_q;
        ovr_d   = ovr_q;
        stale_d = stale_q;
        unique case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_CALC;
                    ax_d    = '0;
                    acc_d   = acc_pick;
                end
            end
            S_CALC: begin
                state_d = S_WB;
                stale_d = tgt_wr && !est
                          && (tgt_idx == ax_q)
                          && (tgt_val != tgt_q[ax_q]);
            end
            S_WB: begin
                if (ax_q == IDX_W'(N_AX - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                    ax_d    = ax_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (tick && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end
    end

    // Value vel will hold after this edge, for the write-clears-at rule
    assign vel_nx = (state_q == S_WB && ax_q == tgt_idx)
                    ? nxt_q : vel_q[tgt_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ax_q    <= '0;
            acc_q   <= '0;
            ovr_q   <= 1'b0;
            at_q    <= '1;
            nxt_q   <= '0;
            eq_q    <= 1'b0;
            stale_q <= 1'b0;
            for (int k = 0; k < N_AX; k++) begin
                tgt_q[k] <= '0;
                vel_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            acc_q   <= acc_d;
            ovr_q   <= ovr_d;
            stale_q <= stale_d;
            if (state_q == S_CALC) begin
                nxt_q <= alu_nxt;
                eq_q  <= alu_eq;
            end
            if (state_q == S_WB) begin
                vel_q[ax_q] <= nxt_q;
                at_q[ax_q]  <= eq_q & ~stale_q;
            end
            if (tgt_wr) begin
                tgt_q[tgt_idx] <= tgt_val;
                if (tgt_val != vel_nx) begin
                    at_q[tgt_idx] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < N_AX; k++) begin : g_out
        assign vel_out[k*VW +: VW] = vel_q[k];
    end

    assign at_target = at_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_vel_ramp_sched.sv
// Scoreboard bench for vel_ramp_sched: a behavioural ramp model queues
// expected velocities per pass, compared when the DUT pulses done.
module tb_vel_ramp_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        tgt_wr;
    logic [1:0]  tgt_idx;
    logic [11:0] tgt_val;
    logic [7:0]  acc;
    logic        estop;
    logic [47:0] vel_out;
    logic [3:0]  at_target;
    logic        busy;
    logic        done;
    logic        overrun;

    vel_ramp_sched dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .tgt_wr    (tgt_wr),
        .tgt_idx   (tgt_idx),
        .tgt_val   (tgt_val),
        .acc       (acc),
        .estop     (estop),
        .vel_out   (vel_out),
        .at_target (at_target),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] vel;
        logic [3:0]  at;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   mtgt[4];
    int   mvel[4];
    logic [3:0] mat;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [47:0] pack_vel();
        logic [47:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            v[k*12 +: 12] = 12'(mvel[k]);
        end
        return v;
    endfunction

    task automatic model_pass(input int a, input bit es);
        int eff;
        int d;
        if (es && a == 0) a = 255;
        for (int k = 0; k < 4; k++) begin
            eff = es ? 0 : mtgt[k];
            d = eff - mvel[k];
            if ((d < 0 ? -d : d) <= a) mvel[k] = eff;
            else if (d > 0) mvel[k] += a;
            else mvel[k] -= a;
            mat[k] = (mvel[k] == eff);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mtgt[k] = 0;
            mvel[k] = 0;
        end
        mat = 4'hF;
    endtask

    task automatic wr_tgt(input logic [1:0] i, input int v);
        @(negedge clk);
        tgt_wr = 1'b1;
        tgt_idx = i;
        tgt_val = 12'(v);
        @(negedge clk);
        tgt_wr = 1'b0;
        mtgt[i] = v;
        if (v != mvel[i]) mat[i] = 1'b0;
        chk("at_wr", at_target, mat);
    endtask

    // One ramp pass; optional target write in CALC(0), optional 2nd tick
    task automatic do_pass(input int a, input bit wr,
                           input logic [1:0] wi, input int wv,
                           input bit t2, input bit es);
        exp_t e;
        int cyc;
        @(negedge clk);
        acc = 8'(a);
        estop = es;
        tick = 1'b1;
        if (wr && wi != 2'd0) mtgt[wi] = wv;
        model_pass(a, es);
        if (wr && wi == 2'd0) begin
            mtgt[0] = wv;
            mat[0] = (mvel[0] == wv);
        end
        e.vel = pack_vel();
        e.at = mat;
        sb.push_back(e);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            tick = t2 && (cyc == 4);
            tgt_wr = wr && (cyc == 1);
            tgt_idx = wi;
            tgt_val = 12'(wv);
        end while (!done && cyc < 40);
        tick = 1'b0;
        tgt_wr = 1'b0;
        chk("done_lat", cyc, 9);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("sb_empty", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("vel", vel_out, e.vel);
                chk("at", at_target, e.at);
            end
        end
    end

    initial begin
        int d0;
        int cyc;
        rst = 1'b1;
        tick = 1'b0;
        tgt_wr = 1'b0;
        tgt_idx = '0;
        tgt_val = '0;
        acc = '0;
        estop = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_vel", vel_out, 48'd0);
        chk("rst_at", at_target, 4'hF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovr", overrun, 1'b0);

        // Positive ramp on axis 0
        wr_tgt(2'd0, 10);
        repeat (3) do_pass(4, 0, 0, 0, 0, 0);

        // Negative ramp on axis 1
        wr_tgt(2'd1, -7);
        repeat (3) do_pass(3, 0, 0, 0, 0, 0);

        // Zero acceleration holds velocity
        wr_tgt(2'd2, 5);
        do_pass(0, 0, 0, 0, 0, 0);
`ifdef RAMP_ESTOP_EN
        do_pass(0, 0, 0, 0, 0, 1);
        estop = 1'b0;
`endif

        // Mid-pass writes: axis 3 applies now, axis 0 next pass
        do_pass(4, 1, 2'd3, -5, 0, 0);
        do_pass(4, 1, 2'd0, 20, 0, 0);
        do_pass(4, 0, 0, 0, 0, 0);

        // Second tick while busy is dropped
        d0 = done_cnt;
        chk("ovr_pre", overrun, 1'b0);
        do_pass(4, 0, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        chk("ovr_set", overrun, 1'b1);
        chk("done_once", done_cnt - d0, 1);
        chk("idle_after", busy, 1'b0);

        // Full-scale negative then full-scale swing
        wr_tgt(2'd1, -2048);
        repeat (9) do_pass(255, 0, 0, 0, 0, 0);
        wr_tgt(2'd1, 2047);
        do_pass(255, 0, 0, 0, 0, 0);

        // Reset in WB(2) aborts the pass
        @(negedge clk);
        acc = 8'd4;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cyc = 1;
        while (cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_mid", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr_vel", vel_out, 48'd0);
        chk("rr_at", at_target, 4'hF);
        chk("rr_busy", busy, 1'b0);
        chk("rr_done", done, 1'b0);
        chk("rr_ovr", overrun, 1'b0);
        model_reset();
        wr_tgt(2'd2, 3);
        do_pass(2, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
